// File: rtl/vga_timing_detector_pkg.sv
// Shared constants and types for the VGA timing detector (800x600@72 defaults).
// Build option VGA_DETECT_SYNC_EN lives in the sync/edge sub-module.
package vga_timing_detector_pkg;

   localparam int COORDINATE_WIDTH = 11;
   localparam int H_BACK_DEF       = 64;
   localparam int H_VISIBLE_DEF    = 800;
   localparam int V_BACK_DEF       = 23;
   localparam int V_VISIBLE_DEF    = 600;
   localparam int LOCK_FRAMES_DEF  = 2;

   // Frame-check progress: nothing seen, one vrise seen, reference held
   typedef enum logic [1:0] {
      CHK_IDLE,
      CHK_ARMED,
      CHK_TRACK
   } chk_state_t;

   function automatic logic in_window(input int unsigned pos,
                                      input int unsigned lo,
                                      input int unsigned len);
      return (pos >= lo) && (pos < lo + len);
   endfunction

endpackage

// File: rtl/vga_timing_detector_sync_edge_detect.sv
// Optional 2-flop synchronizer plus enabled history register and edge strobes.
// Define VGA_DETECT_SYNC_EN to insert the synchronizer (flops reset to 1).
module vga_timing_detector_sync_edge_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic i_en,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic w_sig;
   logic r_hist;

`ifdef VGA_DETECT_SYNC_EN
   logic [1:0] r_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_sig};
      end
   end

   assign w_sig = r_sync[1];
`else
   assign w_sig = i_sig;
`endif

   // History only advances on enabled cycles so vsync is tracked per line
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hist <= 1'b0;
      end else if (i_en) begin
         r_hist <= w_sig;
      end
   end

   assign o_rise = i_en &  w_sig & ~r_hist;
   assign o_fall = i_en & ~w_sig &  r_hist;

endmodule

// File: rtl/vga_timing_detector.sv
// Receive-side VGA timing detector: measures sync timing, regenerates position, reports lock.
// Build option VGA_DETECT_SYNC_EN adds input synchronizers (3 clk position lag instead of 1).
module vga_timing_detector
   import vga_timing_detector_pkg::*;
#(
   parameter int COORD_W     = COORDINATE_WIDTH,
   parameter int H_BACK      = H_BACK_DEF,
   parameter int H_VISIBLE   = H_VISIBLE_DEF,
   parameter int V_BACK      = V_BACK_DEF,
   parameter int V_VISIBLE   = V_VISIBLE_DEF,
   parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               hsync,
   input  logic               vsync,
   output logic [COORD_W-1:0] xpos,
   output logic [COORD_W-1:0] ypos,
   output logic               drawing,
   output logic [COORD_W-1:0] line_total,
   output logic [COORD_W-1:0] hpulse_width,
   output logic [COORD_W-1:0] frame_total,
   output logic [COORD_W-1:0] vpulse_width,
   output logic               locked,
   output logic               timing_err,
   output logic               no_signal
);

   logic w_hrise, w_hfall, w_vrise, w_vfall;

   logic [COORD_W-1:0] r_hcnt, r_hs_pos, r_line_total, r_hpulse;
   logic [COORD_W-1:0] r_ycnt, r_vs_pos, r_frame_total, r_vpulse;
   logic               r_line_bad, r_no_signal, r_locked, r_timing_err;

   logic [COORD_W-1:0] w_hcnt_p1, w_ycnt_p1, w_hpulse_new, w_vpulse_new;
   logic               w_hsat, w_loss, w_line_mismatch, w_frame_ok;

   chk_state_t           r_state, w_state_next;
   logic [4*COORD_W-1:0] r_ref, w_ref_next, w_tuple;
   logic [3:0]           r_match_cnt, w_match_next, w_match_inc;
   logic                 w_locked_next, w_err_next;

   vga_timing_detector_sync_edge_detect u_hsync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (1'b1),
      .i_sig   (hsync),
      .o_rise  (w_hrise),
      .o_fall  (w_hfall)
   );

   vga_timing_detector_sync_edge_detect u_vsync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (w_hrise),
      .i_sig   (vsync),
      .o_rise  (w_vrise),
      .o_fall  (w_vfall)
   );

   assign w_hcnt_p1       = r_hcnt + COORD_W'(1);
   assign w_ycnt_p1       = r_ycnt + COORD_W'(1);
   assign w_hpulse_new    = w_hcnt_p1 - r_hs_pos;
   assign w_vpulse_new    = w_ycnt_p1 - r_vs_pos;
   assign w_hsat          = &r_hcnt;
   assign w_loss          = w_hsat & ~w_hrise;
   assign w_line_mismatch = (w_hcnt_p1 != r_line_total);

   // vrise always coincides with hrise, so these are the values being latched this cycle
   assign w_tuple    = {w_hcnt_p1, w_hpulse_new, w_ycnt_p1, w_vpulse_new};
   assign w_frame_ok = (w_tuple == r_ref) & ~r_line_bad & ~w_line_mismatch;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hcnt       <= '0;
         r_hs_pos     <= '0;
         r_line_total <= '0;
         r_hpulse     <= '0;
         r_line_bad   <= 1'b0;
         r_no_signal  <= 1'b0;
      end else begin
         if (w_hrise) begin
            r_hcnt <= '0;
         end else if (!w_hsat) begin
            r_hcnt <= w_hcnt_p1;
         end
         if (w_hfall) begin
            r_hs_pos <= w_hcnt_p1;
         end
         if (w_hrise) begin
            r_line_total <= w_hcnt_p1;
            r_hpulse     <= w_hpulse_new;
         end
         if (w_vrise) begin
            r_line_bad <= 1'b0;
         end else if (w_hrise && w_line_mismatch) begin
            r_line_bad <= 1'b1;
         end
         if (w_hrise) begin
            r_no_signal <= 1'b0;
         end else if (w_hsat) begin
            r_no_signal <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ycnt        <= '0;
         r_vs_pos      <= '0;
         r_frame_total <= '0;
         r_vpulse      <= '0;
      end else begin
         if (w_vrise) begin
            r_ycnt <= '0;
         end else if (w_hrise && !(&r_ycnt)) begin
            r_ycnt <= w_ycnt_p1;
         end
         if (w_vfall) begin
            r_vs_pos <= w_ycnt_p1;
         end
         if (w_vrise) begin
            r_frame_total <= w_ycnt_p1;
            r_vpulse      <= w_vpulse_new;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= CHK_IDLE;
         r_ref        <= '0;
         r_match_cnt  <= '0;
         r_locked     <= 1'b0;
         r_timing_err <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_ref        <= w_ref_next;
         r_match_cnt  <= w_match_next;
         r_locked     <= w_locked_next;
         r_timing_err <= w_err_next;
      end
   end

   assign w_match_inc = (r_match_cnt == 4'hF) ? r_match_cnt : r_match_cnt + 4'd1;

   always_comb begin
      w_state_next  = r_state;
      w_ref_next    = r_ref;
      w_match_next  = r_match_cnt;
      w_locked_next = r_locked;
      w_err_next    = 1'b0;
      if (w_loss) begin
         w_state_next  = CHK_IDLE;
         w_match_next  = '0;
         w_locked_next = 1'b0;
         w_err_next    = r_locked;
      end else if (w_vrise) begin
         case (r_state)
            CHK_IDLE: begin
               // Frame before the first vrise is partial; only arm
               w_state_next = CHK_ARMED;
            end
            CHK_ARMED: begin
               w_state_next = CHK_TRACK;
               w_ref_next   = w_tuple;
               w_match_next = '0;
            end
            CHK_TRACK: begin
               if (w_frame_ok) begin
                  w_match_next = w_match_inc;
                  if (w_match_inc >= 4'(LOCK_FRAMES)) begin
                     w_locked_next = 1'b1;
                  end
               end else begin
                  w_match_next  = '0;
                  w_ref_next    = w_tuple;
                  w_locked_next = 1'b0;
                  w_err_next    = r_locked;
               end
            end
            default: begin
               w_state_next = CHK_IDLE;
            end
         endcase
      end
   end

   assign xpos         = r_hcnt;
   assign ypos         = r_ycnt;
   assign line_total   = r_line_total;
   assign hpulse_width = r_hpulse;
   assign frame_total  = r_frame_total;
   assign vpulse_width = r_vpulse;
   assign locked       = r_locked;
   assign timing_err   = r_timing_err;
   assign no_signal    = r_no_signal;
   assign drawing      = r_locked
                       & in_window(32'(r_hcnt), H_BACK, H_VISIBLE)
                       & in_window(32'(r_ycnt), V_BACK, V_VISIBLE);

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench for vga_timing_detector using a reduced 40x20 raster and a position scoreboard.
module tb_vga_timing_detector;

   localparam int CW = 11;
   localparam int HB = 6, HV = 24, VB = 2, VV = 12, LF = 2;
   localparam int LT = 40, HP = 6, FT = 20, VP = 4;
`ifdef VGA_DETECT_SYNC_EN
   localparam int LAG = 3;
`else
   localparam int LAG = 1;
`endif

   logic          clk = 1'b0;
   logic          reset_n, hsync, vsync;
   logic [CW-1:0] xpos, ypos, line_total, hpulse_width, frame_total, vpulse_width;
   logic          drawing, locked, timing_err, no_signal;

   always #5 clk = ~clk;

   vga_timing_detector #(
      .COORD_W     (CW),
      .H_BACK      (HB),
      .H_VISIBLE   (HV),
      .V_BACK      (VB),
      .V_VISIBLE   (VV),
      .LOCK_FRAMES (LF)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .hsync        (hsync),
      .vsync        (vsync),
      .xpos         (xpos),
      .ypos         (ypos),
      .drawing      (drawing),
      .line_total   (line_total),
      .hpulse_width (hpulse_width),
      .frame_total  (frame_total),
      .vpulse_width (vpulse_width),
      .locked       (locked),
      .timing_err   (timing_err),
      .no_signal    (no_signal)
   );

   typedef struct {
      int x;
      int y;
      bit masked;
   } pos_t;

   pos_t sb[$];
   int   checks = 0, errors = 0;
   int   gx, gy, line_len, seen, need, draw_cnt, err_pulses;
   bit   hold, long_req, fault_pending, track;
   bit   exp_locked, exp_err, exp_nosig, frame_full;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit win(input int x, input int y);
      return (x >= HB) && (x < HB + HV) && (y >= VB) && (y < VB + VV);
   endfunction

   task automatic drive_push();
      pos_t p;
      hsync = hold ? 1'b1 : !(gx >= line_len - HP);
      vsync = !(gy >= FT - VP);
      p.x = gx;
      p.y = gy;
      p.masked = hold;
      sb.push_back(p);
   endtask

   task automatic advance();
      gx++;
      if (gx == line_len) begin
         gx = 0;
         gy = (gy == FT - 1) ? 0 : gy + 1;
         line_len = LT;
         if (long_req && gy == 5) begin
            line_len = LT + 1;
            long_req = 1'b0;
            fault_pending = 1'b1;
         end
      end
   endtask

   // A generator frame start as seen by the detector
   task automatic on_event();
      if (fault_pending) begin
         exp_err = exp_locked;
         exp_locked = 1'b0;
         fault_pending = 1'b0;
         seen = 0;
         need = LF;
      end else begin
         seen++;
         if (seen >= need) exp_locked = 1'b1;
      end
      if (frame_full) check("draw_per_frame", 32'(draw_cnt), 32'(HV * VV));
      draw_cnt = 0;
      frame_full = exp_locked;
      if (exp_locked) begin
         check("line_total", 32'(line_total), 32'(LT));
         check("hpulse_width", 32'(hpulse_width), 32'(HP));
         check("frame_total", 32'(frame_total), 32'(FT));
         check("vpulse_width", 32'(vpulse_width), 32'(VP));
      end
   endtask

   task automatic step();
      pos_t e;
      @(posedge clk);
      #1;
      exp_err = 1'b0;
      if (sb.size() >= LAG) begin
         e = sb.pop_front();
         if (reset_n && !e.masked && e.x == 0) begin
            exp_nosig = 1'b0;
            if (e.y == 0) on_event();
         end
         if (track) begin
            check("locked", 32'(locked), 32'(exp_locked));
            check("timing_err", 32'(timing_err), 32'(exp_err));
            check("no_signal", 32'(no_signal), 32'(exp_nosig));
            check("drawing", 32'(drawing), 32'(exp_locked && win(e.x, e.y)));
            if (exp_locked) begin
               check("xpos", 32'(xpos), 32'(e.x));
               check("ypos", 32'(ypos), 32'(e.y));
            end
            if (drawing === 1'b1) draw_cnt++;
         end else if (timing_err === 1'b1) begin
            err_pulses++;
         end
      end
      advance();
      drive_push();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_xpos"}, 32'(xpos), 0);
      check({tag, "_ypos"}, 32'(ypos), 0);
      check({tag, "_line_total"}, 32'(line_total), 0);
      check({tag, "_hpulse"}, 32'(hpulse_width), 0);
      check({tag, "_frame_total"}, 32'(frame_total), 0);
      check({tag, "_vpulse"}, 32'(vpulse_width), 0);
      check({tag, "_drawing"}, 32'(drawing), 0);
      check({tag, "_locked"}, 32'(locked), 0);
      check({tag, "_timing_err"}, 32'(timing_err), 0);
      check({tag, "_no_signal"}, 32'(no_signal), 0);
   endtask

   task automatic run_to_lock(input string tag);
      for (int i = 0; i < 7 * LT * FT; i++) begin
         step();
         if (exp_locked) break;
      end
      check(tag, 32'(locked), 1);
      $display("lock %s at t=%0t", tag, $time);
   endtask

   initial begin
      reset_n = 1'b0;
      hold = 1'b0; long_req = 1'b0; fault_pending = 1'b0; track = 1'b1;
      exp_locked = 1'b0; exp_err = 1'b0; exp_nosig = 1'b0; frame_full = 1'b0;
      seen = 0; need = 4; draw_cnt = 0; err_pulses = 0;
      gx = 17; gy = 5; line_len = LT;
      drive_push();
      repeat (3) step();
      check_all_zero("reset");

      // Release mid-frame, lock after four frame starts, then run locked
      reset_n = 1'b1;
      run_to_lock("initial_lock");
      repeat (3 * LT * FT) step();

      // One line stretched by a pixel breaks lock at the next frame start
      long_req = 1'b1;
      repeat (4 * LT * FT) step();
      check("relock_after_long_line", 32'(locked), 1);

      // Loss of hsync
      for (int i = 0; i < LT * FT && !(gx == 5 && gy == 10); i++) step();
      track = 1'b0; hold = 1'b1; frame_full = 1'b0; err_pulses = 0;
      for (int i = 0; i < 4000 && !(i >= 2100 && gx == 5 && gy == 8); i++) step();
      check("loss_no_signal", 32'(no_signal), 1);
      check("loss_locked", 32'(locked), 0);
      check("loss_err_pulses", 32'(err_pulses), 1);
      $display("loss phase done at t=%0t err_pulses=%0d", $time, err_pulses);
      hold = 1'b0; exp_locked = 1'b0; exp_nosig = 1'b1; seen = 0; need = 4; track = 1'b1;
      run_to_lock("lock_after_loss");
      repeat (LT * FT) step();

      // Asynchronous reset mid-frame while locked
      for (int i = 0; i < LT * FT && !(gx == 20 && gy == 7); i++) step();
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      exp_locked = 1'b0; frame_full = 1'b0; seen = 0; need = 4;
      repeat (5) step();
      reset_n = 1'b1;
      run_to_lock("lock_after_reset");
      repeat (LT * FT) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
